// File: rtl/wb_clint_pkg.sv
// Shared register map and constants for the Wishbone core-local interruptor.
package wb_clint_pkg;

    localparam int unsigned PRESCALE_W = 16;

    // Word offsets on i_wb_adr[4:2]
    localparam logic [2:0] CLINT_MTIME_LO    = 3'd0;
    localparam logic [2:0] CLINT_MTIME_HI    = 3'd1;
    localparam logic [2:0] CLINT_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] CLINT_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] CLINT_MSIP        = 3'd4;
    localparam logic [2:0] CLINT_PRESCALE    = 3'd5;

    // Replace only the byte lanes enabled in sel.
    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[i*8 +: 8] = wdat[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_clint_prescaler.sv
// Down-counting prescaler: emits o_tick while the count is zero, then reloads.
module wb_clint_prescaler
    import wb_clint_pkg::*;
#(
    parameter logic [PRESCALE_W-1:0] RST_VAL = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [PRESCALE_W-1:0] i_reload,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= RST_VAL;
        end else if (i_load || cnt == '0) begin
            cnt <= i_reload;
        end else begin
            cnt <= cnt - PRESCALE_W'(1);
        end
    end

    // A load in the tick cycle still lets that tick through.
    assign o_tick = (cnt == '0);

endmodule

// File: rtl/wb_clint.sv
// Wishbone CLINT: prescaled 64-bit mtime, mtimecmp compare and msip software interrupt.
module wb_clint
    import wb_clint_pkg::*;
#(
    parameter logic [PRESCALE_W-1:0] PRESCALE_RST = '0,
    parameter logic [63:0]           MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [4:2]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq,
    output logic        o_sw_irq
);

    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic [31:0]           shadow;
    logic [PRESCALE_W-1:0] prescale;
    logic                  msip;

    logic                  req_c, wr_c, rd_c, tick_c;
    logic [31:0]           prescale_wr_c;
    logic [PRESCALE_W-1:0] prescale_nxt_c;
    logic [31:0]           rd_mux_c;

    // Ack is high for exactly one cycle, so a held strobe is served every other cycle.
    assign req_c = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr_c  = req_c & i_wb_we;
    assign rd_c  = req_c & ~i_wb_we;

    assign prescale_wr_c  = byte_merge(32'(prescale), i_wb_dat, i_wb_sel);
    assign prescale_nxt_c = (wr_c && i_wb_adr == CLINT_PRESCALE) ?
                            prescale_wr_c[PRESCALE_W-1:0] : prescale;

    wb_clint_prescaler #(
        .RST_VAL (PRESCALE_RST)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (wr_c && i_wb_adr == CLINT_PRESCALE),
        .i_reload (prescale_nxt_c),
        .o_tick   (tick_c)
    );

    always_comb begin
        rd_mux_c = '0;
        case (i_wb_adr)
            CLINT_MTIME_LO:    rd_mux_c = mtime[31:0];
            CLINT_MTIME_HI:    rd_mux_c = shadow;
            CLINT_MTIMECMP_LO: rd_mux_c = mtimecmp[31:0];
            CLINT_MTIMECMP_HI: rd_mux_c = mtimecmp[63:32];
            CLINT_MSIP:        rd_mux_c = 32'(msip);
            CLINT_PRESCALE:    rd_mux_c = 32'(prescale);
            default:           rd_mux_c = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_ack    <= 1'b0;
            o_wb_rdt    <= '0;
            o_timer_irq <= 1'b0;
            mtime       <= '0;
            mtimecmp    <= MTIMECMP_RST;
            shadow      <= '0;
            prescale    <= PRESCALE_RST;
            msip        <= 1'b0;
        end else begin
            o_wb_ack    <= req_c;
            o_wb_rdt    <= rd_c ? rd_mux_c : '0;
            o_timer_irq <= (mtime >= mtimecmp);
            prescale    <= prescale_nxt_c;

            // A write to either half of mtime drops this cycle's tick entirely.
            if (wr_c && i_wb_adr == CLINT_MTIME_LO) begin
                mtime[31:0] <= byte_merge(mtime[31:0], i_wb_dat, i_wb_sel);
            end else if (wr_c && i_wb_adr == CLINT_MTIME_HI) begin
                mtime[63:32] <= byte_merge(mtime[63:32], i_wb_dat, i_wb_sel);
            end else if (tick_c) begin
                mtime <= mtime + 64'd1;
            end

            if (wr_c && i_wb_adr == CLINT_MTIMECMP_LO) begin
                mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], i_wb_dat, i_wb_sel);
            end
            if (wr_c && i_wb_adr == CLINT_MTIMECMP_HI) begin
                mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], i_wb_dat, i_wb_sel);
            end

            if (wr_c && i_wb_adr == CLINT_MSIP && i_wb_sel[0]) begin
                msip <= i_wb_dat[0];
            end

            // Reading the low word freezes the high word for a following read.
            if (rd_c && i_wb_adr == CLINT_MTIME_LO) begin
                shadow <= mtime[63:32];
            end
        end
    end

    assign o_sw_irq = msip;

endmodule

// File: tb/tb_wb_clint.sv
// Directed self-checking bench for wb_clint.
module tb_wb_clint;
    import wb_clint_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [2:0]  wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        timer_irq;
    logic        sw_irq;

    int n_checks = 0;
    int n_fail   = 0;

    wb_clint dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wb_adr    (wb_adr),
        .i_wb_dat    (wb_dat),
        .i_wb_sel    (wb_sel),
        .i_wb_we     (wb_we),
        .i_wb_cyc    (wb_cyc),
        .i_wb_stb    (wb_stb),
        .o_wb_rdt    (wb_rdt),
        .o_wb_ack    (wb_ack),
        .o_timer_irq (timer_irq),
        .o_sw_irq    (sw_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single transfer; called and returns 1ns after a rising edge.
    task automatic wb_xfer(input logic [2:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdt);
        bit done;
        done = 1'b0;
        rdt  = '0;
        wb_adr = adr; wb_we = we; wb_dat = dat; wb_sel = sel;
        wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            @(posedge clk); #1;
            if (wb_ack) begin
                done = 1'b1;
                rdt  = wb_rdt;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL wb_ack_timeout: got no ack, expected ack within 8 cycles (adr %0d)", adr);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        wb_adr = '0; wb_dat = '0; wb_sel = '0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", wb_ack); end
        n_checks++; if (wb_rdt !== 32'd0) begin n_fail++; $display("FAIL reset_rdt: got %h expected 0", wb_rdt); end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_timer_irq: got %b expected 0 (cycle %0d)", timer_irq, k); end
            n_checks++; if (sw_irq !== 1'b0) begin n_fail++; $display("FAIL reset_sw_irq: got %b expected 0 (cycle %0d)", sw_irq, k); end
        end
        wb_xfer(CLINT_MTIME_LO, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'd10) begin n_fail++; $display("FAIL reset_mtime_lo: got %0d expected 10", d); end
        wb_xfer(CLINT_MTIMECMP_HI, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_mtimecmp_hi: got %h expected ffffffff", d); end
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        logic [31:0] exp;
        wb_xfer(CLINT_MTIME_LO, 1'b1, 32'd1000, 4'hF, d);
        wb_xfer(CLINT_PRESCALE, 1'b1, 32'd3, 4'b0011, d);
        // Each read samples mtime after edge W+1+2j; ticks land on W+4, W+8, ...
        for (int j = 0; j < 20; j++) begin
            wb_xfer(CLINT_MTIME_LO, 1'b0, '0, 4'hF, d);
            exp = 32'd1002 + 32'((1 + 2 * j) / 4);
            n_checks++; if (d !== exp) begin n_fail++; $display("FAIL prescale_mtime_lo[%0d]: got %0d expected %0d", j, d, exp); end
        end
        wb_xfer(CLINT_PRESCALE, 1'b1, 32'd0, 4'hF, d);
    endtask

    task automatic test_atomic();
        logic [31:0] lo, hi, d;
        wb_xfer(CLINT_MTIME_LO, 1'b1, 32'hFFFF_FFFE, 4'hF, d);
        wb_xfer(CLINT_MTIME_HI, 1'b1, 32'h0000_0001, 4'hF, d);
        wb_xfer(CLINT_MTIME_LO, 1'b0, '0, 4'hF, lo);
        wb_xfer(CLINT_MTIME_HI, 1'b0, '0, 4'hF, hi);
        n_checks++; if ({hi, lo} !== 64'h2_0000_0000) begin n_fail++; $display("FAIL atomic_carry: got %h_%h expected 00000002_00000000", hi, lo); end
        // Low word read just before the carry; the high read must come from the shadow.
        wb_xfer(CLINT_MTIME_HI, 1'b1, 32'h0000_0001, 4'hF, d);
        wb_xfer(CLINT_MTIME_LO, 1'b1, 32'hFFFF_FFFD, 4'hF, d);
        wb_xfer(CLINT_MTIME_LO, 1'b0, '0, 4'hF, lo);
        wb_xfer(CLINT_MTIME_HI, 1'b0, '0, 4'hF, hi);
        n_checks++; if ({hi, lo} !== 64'h1_FFFF_FFFE) begin n_fail++; $display("FAIL atomic_shadow: got %h_%h expected 00000001_fffffffe", hi, lo); end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        logic        exp;
        wb_xfer(CLINT_MTIME_HI, 1'b1, 32'd0, 4'hF, d);
        wb_xfer(CLINT_MTIME_LO, 1'b1, 32'd0, 4'hF, d);
        wb_xfer(CLINT_MTIMECMP_HI, 1'b1, 32'd0, 4'hF, d);
        wb_xfer(CLINT_MTIMECMP_LO, 1'b1, 32'd100, 4'hF, d);
        // mtime is 4 after the last write edge; irq registers (3+k >= 100) at edge k.
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            exp = (k >= 97);
            n_checks++; if (timer_irq !== exp) begin n_fail++; $display("FAIL timer_rise[%0d]: got %b expected %b", k, timer_irq, exp); end
        end
        wb_xfer(CLINT_MTIMECMP_LO, 1'b1, 32'hFFFF_FFFF, 4'hF, d);
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL timer_hold: got %b expected 1", timer_irq); end
        @(posedge clk); #1;
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL timer_fall: got %b expected 0", timer_irq); end
        wb_xfer(CLINT_MTIMECMP_LO, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mtimecmp_lo_rd: got %h expected ffffffff", d); end
        wb_xfer(CLINT_MTIMECMP_HI, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL mtimecmp_hi_rd: got %h expected 0", d); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        wb_xfer(3'd6, 1'b1, 32'hFFFF_FFFF, 4'hF, d);
        wb_xfer(3'd6, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reserved_rd: got %h expected 0", d); end
        wb_xfer(CLINT_PRESCALE, 1'b1, 32'h0000_0302, 4'b0010, d);
        wb_xfer(CLINT_PRESCALE, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'h0000_0300) begin n_fail++; $display("FAIL prescale_bytelane: got %h expected 00000300", d); end
        wb_xfer(CLINT_PRESCALE, 1'b1, 32'hABCD_0000, 4'hF, d);
        wb_xfer(CLINT_PRESCALE, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL prescale_upper: got %h expected 0", d); end
    endtask

    task automatic test_msip();
        logic [31:0] d;
        wb_xfer(CLINT_MSIP, 1'b1, 32'd1, 4'b0001, d);
        n_checks++; if (sw_irq !== 1'b1) begin n_fail++; $display("FAIL msip_set: got %b expected 1", sw_irq); end
        wb_xfer(CLINT_MSIP, 1'b1, 32'd0, 4'b0010, d);
        n_checks++; if (sw_irq !== 1'b1) begin n_fail++; $display("FAIL msip_sel_clr: got %b expected 1", sw_irq); end
        wb_xfer(CLINT_MSIP, 1'b1, 32'd0, 4'b0001, d);
        n_checks++; if (sw_irq !== 1'b0) begin n_fail++; $display("FAIL msip_clr: got %b expected 0", sw_irq); end
        wb_xfer(CLINT_MSIP, 1'b1, 32'd1, 4'b0010, d);
        n_checks++; if (sw_irq !== 1'b0) begin n_fail++; $display("FAIL msip_sel_set: got %b expected 0", sw_irq); end
        wb_xfer(CLINT_MSIP, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL msip_rd0: got %h expected 0", d); end
        wb_xfer(CLINT_MSIP, 1'b1, 32'hFFFF_FFFF, 4'hF, d);
        wb_xfer(CLINT_MSIP, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL msip_rd1: got %h expected 1", d); end
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        @(posedge clk); #1;
        wb_adr = CLINT_MSIP; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            exp_ack = (k % 2 == 0);
            n_checks++; if (wb_ack !== exp_ack) begin n_fail++; $display("FAIL b2b_ack[%0d]: got %b expected %b", k, wb_ack, exp_ack); end
            n_checks++; if (wb_rdt !== 32'(exp_ack)) begin n_fail++; $display("FAIL b2b_rdt[%0d]: got %h expected %h", k, wb_rdt, 32'(exp_ack)); end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        wb_xfer(CLINT_PRESCALE, 1'b1, 32'h0000_FFFF, 4'b0011, d);
        wb_xfer(CLINT_MTIME_HI, 1'b1, 32'd0, 4'hF, d);
        wb_xfer(CLINT_MTIME_LO, 1'b1, 32'h1234, 4'hF, d);
        wb_xfer(CLINT_MTIME_LO, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'h1234) begin n_fail++; $display("FAIL rstmid_pre: got %h expected 1234", d); end
        @(posedge clk); #1;
        wb_adr = CLINT_MTIME_LO; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (wb_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_ack_before: got %b expected 1", wb_ack); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack_async: got %b expected 0", wb_ack); end
        n_checks++; if (wb_rdt !== 32'd0) begin n_fail++; $display("FAIL rstmid_rdt: got %h expected 0", wb_rdt); end
        n_checks++; if (sw_irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_sw_irq: got %b expected 0", sw_irq); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        wb_xfer(CLINT_MTIME_LO, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_mtime: got %h expected 0", d); end
        wb_xfer(CLINT_MTIME_HI, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_shadow: got %h expected 0", d); end
        wb_xfer(CLINT_MTIMECMP_LO, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rstmid_cmp_lo: got %h expected ffffffff", d); end
        wb_xfer(CLINT_MTIMECMP_HI, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rstmid_cmp_hi: got %h expected ffffffff", d); end
        wb_xfer(CLINT_PRESCALE, 1'b0, '0, 4'hF, d);
        n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_prescale: got %h expected 0", d); end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_atomic();
        test_timer();
        test_regs();
        test_msip();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
